// File: rtl/telemetry_pkg.sv
// Shared constants and state encodings for the telemetry receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package telemetry_pkg;
    localparam logic [7:0] HDR0          = 8'hAA;
    localparam logic [7:0] HDR1          = 8'h55;
    localparam int         PAYLOAD_BYTES = 6;
    localparam int         CNT_W         = 12;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_st_t;
    typedef enum logic [1:0] {WAIT_AA, WAIT_55, PAYLOAD, CHK} frm_st_t;
endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte deserializer with 2-flop RX synchronizer and mid-bit sampling.
// Latency: byte_rdy/stop_err pulse one clk after the mid-stop-bit sample.
// Backpressure: none; each byte is presented once and must be consumed on byte_rdy.
module uart_rx_byte
    import telemetry_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       byte_rdy,
    output logic       stop_err
);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    byte_st_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_rdy_q, byte_rdy_d;
    logic             stop_err_q, stop_err_d;

    // Synchronizer and edge-detect history, preset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Byte FSM and datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_rdy_q <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_rdy_q <= byte_rdy_d;
            stop_err_q <= stop_err_d;
        end
    end

    // Next state: wait half a bit to confirm the start, then sample every full bit period.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_rdy_d = 1'b0;
        stop_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line already back high at mid start bit was a glitch.
                    state_d = rx_sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    state_d    = IDLE;
                    byte_rdy_d = rx_sync_q;
                    stop_err_d = !rx_sync_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data  = shift_q;
    assign byte_rdy = byte_rdy_q;
    assign stop_err = stop_err_q;
endmodule

// File: rtl/telemetry_rx.sv
// Telemetry frame receiver: header lock on AA 55, unpacks 12-bit batt/curr/torque. Option macro: TELEM_CHKSUM_EN.
// Latency: outputs and vld update one clk after the last frame byte's byte_rdy.
// Backpressure: none; results are a one-cycle strobe, values hold until the next good frame.
module telemetry_rx
    import telemetry_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        vld,
    output logic        frm_err,
    output logic        chk_err
);
    logic [7:0] rx_data;
    logic       byte_rdy;
    logic       stop_err;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .rx_data  (rx_data),
        .byte_rdy (byte_rdy),
        .stop_err (stop_err)
    );

    frm_st_t     frm_st_q, frm_st_d;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] bat_sh_q, bat_sh_d, cur_sh_q, cur_sh_d, trq_sh_q, trq_sh_d;
    logic [11:0] batt_q, batt_d, curr_q, curr_d, torque_q, torque_d;
    logic        vld_q, vld_d, frm_err_q, frm_err_d;
`ifdef TELEM_CHKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        chk_err_q, chk_err_d;
`endif

    // Frame FSM, shadow and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_st_q  <= WAIT_AA;
            idx_q     <= '0;
            bat_sh_q  <= '0;
            cur_sh_q  <= '0;
            trq_sh_q  <= '0;
            batt_q    <= '0;
            curr_q    <= '0;
            torque_q  <= '0;
            vld_q     <= 1'b0;
            frm_err_q <= 1'b0;
`ifdef TELEM_CHKSUM_EN
            sum_q     <= '0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            frm_st_q  <= frm_st_d;
            idx_q     <= idx_d;
            bat_sh_q  <= bat_sh_d;
            cur_sh_q  <= cur_sh_d;
            trq_sh_q  <= trq_sh_d;
            batt_q    <= batt_d;
            curr_q    <= curr_d;
            torque_q  <= torque_d;
            vld_q     <= vld_d;
            frm_err_q <= frm_err_d;
`ifdef TELEM_CHKSUM_EN
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
`endif
        end
    end

    // Frame parsing: header match, payload unpack into shadows, atomic publish on the final byte.
    always_comb begin
        frm_st_d  = frm_st_q;
        idx_d     = idx_q;
        bat_sh_d  = bat_sh_q;
        cur_sh_d  = cur_sh_q;
        trq_sh_d  = trq_sh_q;
        batt_d    = batt_q;
        curr_d    = curr_q;
        torque_d  = torque_q;
        vld_d     = 1'b0;
        frm_err_d = 1'b0;
`ifdef TELEM_CHKSUM_EN
        sum_d     = sum_q;
        chk_err_d = 1'b0;
`endif
        if (stop_err) begin
            // A corrupted byte anywhere poisons the frame; relock on the next header.
            frm_err_d = 1'b1;
            frm_st_d  = WAIT_AA;
        end else if (byte_rdy) begin
            case (frm_st_q)
                WAIT_AA: begin
                    if (rx_data == HDR0) frm_st_d = WAIT_55;
                end
                WAIT_55: begin
                    if (rx_data == HDR1) begin
                        frm_st_d = PAYLOAD;
                        idx_d    = '0;
`ifdef TELEM_CHKSUM_EN
                        sum_d    = '0;
`endif
                    end else if (rx_data != HDR0) begin
                        // A repeated AA may itself be the true header start, so only other bytes unlock.
                        frm_st_d = WAIT_AA;
                    end
                end
                PAYLOAD: begin
                    if (!idx_q[0] && (rx_data[7:4] != 4'h0)) begin
                        frm_err_d = 1'b1;
                        frm_st_d  = WAIT_AA;
                    end else begin
                        case (idx_q)
                            3'd0:    bat_sh_d[11:8] = rx_data[3:0];
                            3'd1:    bat_sh_d[7:0]  = rx_data;
                            3'd2:    cur_sh_d[11:8] = rx_data[3:0];
                            3'd3:    cur_sh_d[7:0]  = rx_data;
                            3'd4:    trq_sh_d[11:8] = rx_data[3:0];
                            default: trq_sh_d[7:0]  = rx_data;
                        endcase
                        idx_d = idx_q + 1'b1;
`ifdef TELEM_CHKSUM_EN
                        sum_d = sum_q + rx_data;
`endif
                        if (idx_q == 3'(PAYLOAD_BYTES - 1)) begin
`ifdef TELEM_CHKSUM_EN
                            frm_st_d = CHK;
`else
                            batt_d   = bat_sh_d;
                            curr_d   = cur_sh_d;
                            torque_d = trq_sh_d;
                            vld_d    = 1'b1;
                            frm_st_d = WAIT_AA;
`endif
                        end
                    end
                end
`ifdef TELEM_CHKSUM_EN
                CHK: begin
                    if (rx_data == sum_q) begin
                        batt_d   = bat_sh_q;
                        curr_d   = cur_sh_q;
                        torque_d = trq_sh_q;
                        vld_d    = 1'b1;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    frm_st_d = WAIT_AA;
                end
`endif
                default: frm_st_d = WAIT_AA;
            endcase
        end
    end

    assign batt    = batt_q;
    assign curr    = curr_q;
    assign torque  = torque_q;
    assign vld     = vld_q;
    assign frm_err = frm_err_q;
`ifdef TELEM_CHKSUM_EN
    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_telemetry_rx.sv
// Scoreboard bench for telemetry_rx: directed UART frames, expected events queued, monitor compares.
// Latency: n/a.
// Backpressure: n/a.
module tb_telemetry_rx;
    localparam int BD = 32;
    localparam int EV_VLD = 0;
    localparam int EV_FRM = 1;
    localparam int EV_CHK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic [11:0] batt, curr, torque;
    logic        vld, frm_err, chk_err;

    typedef struct {
        int          kind;
        logic [11:0] b;
        logic [11:0] c;
        logic [11:0] t;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [11:0] hb = '0, hc = '0, ht = '0;

    telemetry_rx #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .batt    (batt),
        .curr    (curr),
        .torque  (torque),
        .vld     (vld),
        .frm_err (frm_err),
        .chk_err (chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        exp_t e;
        e.kind = kind; e.b = b; e.c = c; e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        if (!stop) repeat (BD) @(negedge clk);
    endtask

    task automatic send_payload(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte({4'h0, b[11:8]}, 1'b1);
        send_byte(b[7:0], 1'b1);
        send_byte({4'h0, c[11:8]}, 1'b1);
        send_byte(c[7:0], 1'b1);
        send_byte({4'h0, t[11:8]}, 1'b1);
        send_byte(t[7:0], 1'b1);
    endtask

`ifdef TELEM_CHKSUM_EN
    function automatic logic [7:0] csum(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        return 8'({4'h0, b[11:8]} + b[7:0] + {4'h0, c[11:8]} + c[7:0] + {4'h0, t[11:8]} + t[7:0]);
    endfunction
`endif

    task automatic send_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        send_payload(b, c, t);
`ifdef TELEM_CHKSUM_EN
        send_byte(csum(b, c, t), 1'b1);
`endif
    endtask

    // Monitor: pops an expectation on every strobe, and checks outputs hold between strobes.
    initial begin
        exp_t e;
        int   got;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hb = '0; hc = '0; ht = '0;
                check("reset_outputs", {batt, curr, torque}, 36'd0);
            end else begin
                if (vld || frm_err || chk_err) begin
                    got = vld ? EV_VLD : (frm_err ? EV_FRM : EV_CHK);
                    check("single_strobe", 36'(int'(vld) + int'(frm_err) + int'(chk_err)), 36'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event: got kind %0d, expected no event at %0t", got, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", 36'(got), 36'(e.kind));
                        if (vld && e.kind == EV_VLD) begin
                            check("vld_data", {batt, curr, torque}, {e.b, e.c, e.t});
                            hb = e.b; hc = e.c; ht = e.t;
                        end
                    end
                    if (vld && e.kind != EV_VLD) begin
                        hb = batt; hc = curr; ht = torque;
                    end
                end
                if (!vld) check("outputs_hold", {batt, curr, torque}, {hb, hc, ht});
            end
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        check("reset_strobes", {33'd0, vld, frm_err, chk_err}, 36'd0);
        rst_n = 1'b1;
        repeat (2 * BD) @(negedge clk);

        // Basic frame.
        push_ev(EV_VLD, 12'h7FF, 12'h123, 12'hABC);
        send_frame(12'h7FF, 12'h123, 12'hABC);
        check("t1_batt", 36'(batt), 36'h7FF);

        // Garbage and a repeated AA ahead of the header.
        push_ev(EV_VLD, 12'h010, 12'h020, 12'h030);
        send_byte(8'h13, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_frame(12'h010, 12'h020, 12'h030);

        // Good frame, then a frame whose fifth byte has a bad stop bit, then recovery.
        push_ev(EV_VLD, 12'h111, 12'h222, 12'h333);
        send_frame(12'h111, 12'h222, 12'h333);
        push_ev(EV_FRM, '0, '0, '0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h05, 1'b0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h06, 1'b1);
        send_byte(8'h66, 1'b1);
        check("t3_hold", {batt, curr, torque}, {12'h111, 12'h222, 12'h333});
        push_ev(EV_VLD, 12'h456, 12'h789, 12'h0AB);
        send_frame(12'h456, 12'h789, 12'h0AB);

        // Nonzero pad nibble: frame dropped, trailing bytes must not complete it.
        push_ev(EV_FRM, '0, '0, '0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h17, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(8'h00, 1'b1);
        check("t4_hold", {batt, curr, torque}, {12'h456, 12'h789, 12'h0AB});
        push_ev(EV_VLD, 12'hFFF, 12'h000, 12'h800);
        send_frame(12'hFFF, 12'h000, 12'h800);

        // Short low glitch while waiting for 55 must not inject a byte.
        push_ev(EV_VLD, 12'h5A5, 12'hA5A, 12'h00F);
        send_byte(8'hAA, 1'b1);
        RX = 1'b0;
        repeat (BD / 4) @(negedge clk);
        RX = 1'b1;
        repeat (12 * BD) @(negedge clk);
        send_byte(8'h55, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h0F, 1'b1);
`ifdef TELEM_CHKSUM_EN
        send_byte(csum(12'h5A5, 12'hA5A, 12'h00F), 1'b1);
`endif

        // Reset during byte 4 aborts the frame and clears the outputs.
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        RX = 1'b0;
        repeat (3 * BD) @(negedge clk);
        rst_n = 1'b0;
        RX = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_reset_clear", {batt, curr, torque}, 36'd0);
        rst_n = 1'b1;
        repeat (2 * BD) @(negedge clk);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
`ifdef TELEM_CHKSUM_EN
        send_byte(8'h09, 1'b1);
`endif
        check("t5_no_partial", {batt, curr, torque}, 36'd0);
        push_ev(EV_VLD, 12'h321, 12'h654, 12'h987);
        send_frame(12'h321, 12'h654, 12'h987);

`ifdef TELEM_CHKSUM_EN
        // Checksum match, then a checksum one off.
        push_ev(EV_VLD, 12'h7FF, 12'h123, 12'hABC);
        send_payload(12'h7FF, 12'h123, 12'hABC);
        send_byte(csum(12'h7FF, 12'h123, 12'hABC), 1'b1);
        push_ev(EV_CHK, '0, '0, '0);
        send_payload(12'h111, 12'h222, 12'h333);
        send_byte(csum(12'h111, 12'h222, 12'h333) + 8'd1, 1'b1);
        check("t6_hold", {batt, curr, torque}, {12'h7FF, 12'h123, 12'hABC});
`endif

        repeat (4 * BD) @(negedge clk);
        check("pending_events", 36'(exp_q.size()), 36'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
